// File: rtl/audio_sample_sched.sv
// Purpose: paces audio sampling: every PERIOD clocks it starts an ADC conversion and sends the previously captured sample to the PWM.
// Latency: the first strobe comes PERIOD clocks after Enable is sampled high; a sample reaches the PWM one period after it is captured.
// Backpressure: none; a missing ADC reply times out after TIMEOUT clocks and sets the sticky error flag.
module audio_sample_sched #(
    parameter int unsigned PERIOD  = 2074,
    parameter int unsigned TIMEOUT = 512,
    parameter logic [11:0] MID     = 12'h800
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_mute,
    output logic        o_adc_start,
    input  logic        i_adc_valid,
    input  logic [11:0] i_adc_data,
    output logic        o_pwm_valid,
    output logic [11:0] o_pwm_data,
    output logic        o_timeout_err,
    output logic [15:0] o_sample_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        CONVERT   = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_rst_sync;
    logic [15:0] r_per_cnt;
    logic [15:0] r_to_cnt;
    logic [11:0] r_held;
    logic [11:0] r_pwm_data;
    logic [15:0] r_sample_cnt;
    logic        r_adc_start;
    logic        r_pwm_valid;
    logic        r_timeout_err;

    logic        w_rst_n;
    logic        w_tick;
    logic        w_to_exp;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_rst_sync[1];
    assign w_tick   = (r_per_cnt == 16'(PERIOD - 1));
    assign w_to_exp = (r_to_cnt == 16'(TIMEOUT - 1));

    // Scheduler FSM with its period and timeout counters and registered outputs.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= IDLE;
            r_per_cnt     <= 16'd0;
            r_to_cnt      <= 16'd0;
            r_held        <= MID;
            r_pwm_data    <= MID;
            r_sample_cnt  <= 16'd0;
            r_adc_start   <= 1'b0;
            r_pwm_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_adc_start <= 1'b0;
            r_pwm_valid <= 1'b0;
            if (!i_enable) begin
                // Idle: abandon any conversion, hold the last PWM value.
                r_state       <= IDLE;
                r_per_cnt     <= 16'd0;
                r_to_cnt      <= 16'd0;
                r_timeout_err <= 1'b0;
            end else begin
                // The counter starts from 0 when leaving IDLE so the first
                // tick lands exactly PERIOD clocks after Enable rises.
                if (r_state == IDLE || w_tick) begin
                    r_per_cnt <= 16'd0;
                end else begin
                    r_per_cnt <= r_per_cnt + 16'd1;
                end

                case (r_state)
                    IDLE: begin
                        r_state <= WAIT_TICK;
                    end
                    WAIT_TICK: begin
                        if (w_tick) begin
                            r_pwm_valid <= 1'b1;
                            r_adc_start <= 1'b1;
                            r_pwm_data  <= i_mute ? MID : r_held;
                            r_to_cnt    <= 16'd0;
                            r_state     <= CONVERT;
                        end
                    end
                    CONVERT: begin
                        // A reply on the expiry cycle still counts as a capture.
                        if (i_adc_valid) begin
                            r_held       <= i_adc_data;
                            r_sample_cnt <= r_sample_cnt + 16'd1;
                            r_state      <= WAIT_TICK;
                        end else if (w_to_exp) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= WAIT_TICK;
                        end else begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_adc_start   = r_adc_start;
    assign o_pwm_valid   = r_pwm_valid;
    assign o_pwm_data    = r_pwm_data;
    assign o_timeout_err = r_timeout_err;
    assign o_sample_cnt  = r_sample_cnt;

endmodule

// File: doc/audio_sample_sched.md
AUDIO_SAMPLE_SCHED -- requirements
Module: audio_sample_sched

Interface
REQ-001 SHALL have parameter PERIOD, default 2074 (122*17), meaning clocks per audio sample period; legal range 16..65535.
REQ-002 SHALL have parameter TIMEOUT, default 512, meaning max clocks to wait for an ADC result; TIMEOUT < PERIOD-2 is required.
REQ-003 SHALL have parameter MID, default 12'h800, meaning the silence code output when muted or before the first capture.
REQ-004 Clk  input  1  sole clock; all logic on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Enable  input  1  level; 1 = run sample scheduling, 0 = idle.
REQ-007 Mute  input  1  level; 1 = force Pwm_data to MID.
REQ-008 Adc_start  output  1  single-cycle conversion request to the ADC interface.
REQ-009 Adc_valid  input  1  single-cycle strobe; Adc_data is valid.
REQ-010 Adc_data  input  12  unsigned ADC sample.
REQ-011 Pwm_valid  output  1  single-cycle strobe; restarts the PWM period.
REQ-012 Pwm_data  output  12  sample for the PWM; stable between Pwm_valid strobes.
REQ-013 Timeout_err  output  1  sticky; an ADC conversion timed out.
REQ-014 Sample_cnt  output  16  count of successful captures, wraps 16'hFFFF -> 0.

Function
REQ-015 Period counter SHALL count 0..PERIOD-1 while Enable=1 and wrap to 0; "tick" is the cycle the counter equals PERIOD-1.
REQ-016 Counter SHALL be held at 0 while Enable=0, so the first tick occurs PERIOD cycles after Enable is first sampled 1.
REQ-017 FSM states SHALL be IDLE, WAIT_TICK and CONVERT.
REQ-018 IDLE -> WAIT_TICK when Enable=1; any state -> IDLE on the cycle after Enable is sampled 0.
REQ-019 On a tick in WAIT_TICK, the block SHALL, in the same registered cycle, assert Pwm_valid and Adc_start for exactly one cycle and enter CONVERT.
REQ-020 On that Pwm_valid, Pwm_data SHALL equal MID if Mute=1, else the held sample; one-period latency from capture to output.
REQ-021 In CONVERT, Adc_valid=1 SHALL load Adc_data into the held sample, increment Sample_cnt, and return to WAIT_TICK next cycle.
REQ-022 In CONVERT, a timeout counter SHALL count from 0 after Adc_start; when it reaches TIMEOUT-1 without Adc_valid, Timeout_err SHALL set, the held sample SHALL be kept, and the FSM SHALL return to WAIT_TICK.
REQ-023 Adc_valid in the same cycle as timeout expiry SHALL win: capture, no error.
REQ-024 Adc_valid outside CONVERT SHALL be ignored (no capture, no count change).
REQ-025 Timeout_err SHALL clear only on reset or while Enable=0.
REQ-026 Mute changes SHALL affect Pwm_data only at the next Pwm_valid; the held sample and Sample_cnt SHALL update regardless of Mute.
REQ-027 Enable dropping during CONVERT SHALL abandon the conversion; a late Adc_valid SHALL be ignored, and Pwm_data SHALL hold its last value.
REQ-028 Adc_start and Pwm_valid SHALL never assert in IDLE and SHALL never be high for two consecutive cycles.

Reset
REQ-029 While Rst_n=0: state IDLE, counters 0, Adc_start=0, Pwm_valid=0, Pwm_data=MID, held sample=MID, Timeout_err=0, Sample_cnt=0.
REQ-030 Reset assertion mid-conversion SHALL take effect immediately and asynchronously; release SHALL be synchronous to Clk, and operation resumes under REQ-016.

Verification (bench PERIOD=20, TIMEOUT=8 unless noted)
REQ-031 Enable=1 at cycle 0, ADC returns 12'h123 three cycles after each Adc_start -> Pwm_valid/Adc_start at cycles 20,40,60; Pwm_data=12'h800 at 20, 12'h123 at 40; Sample_cnt=2 after 40.
REQ-032 No Adc_valid after the Adc_start at 20 -> Timeout_err=1 at cycle 28; Pwm_data at 40 repeats the prior value; a next capture still increments Sample_cnt.
REQ-033 Adc_valid exactly on the timeout-expiry cycle with 12'hABC -> captured, Timeout_err stays 0.
REQ-034 Mute=1 with held sample 12'hFFF -> Pwm_data=12'h800 at the next tick; Mute=0 -> 12'hFFF at the following tick.
REQ-035 Enable=0 during CONVERT, then a late Adc_valid -> no capture, FSM IDLE, Timeout_err cleared; re-enable -> first tick 20 cycles later.
REQ-036 Rst_n low mid-CONVERT -> all outputs at REQ-029 values without a clock edge; Sample_cnt 16'hFFFF + capture -> 16'h0000.
